// File: rtl/branch_sequencer.sv
// rtl/branch_sequencer.sv - PC sequencer that resolves one branch at a time and holds a flush window after taken branches
module branch_sequencer #(
  parameter int                       ADDRESS_WIDTH          = 32,
  parameter int                       BRANCH_CONDITION_WIDTH = 4,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR           = '0,
  parameter int                       INSTRUCTION_BYTES      = 4,
  parameter int                       FLUSH_CYCLES           = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              stall,
  input  logic                              branch_valid,
  output logic                              branch_ready,
  input  logic [BRANCH_CONDITION_WIDTH-1:0] branch_condition,
  input  logic [ADDRESS_WIDTH-1:0]          branch_target,
  input  logic [ADDRESS_WIDTH-1:0]          branch_pc,
  input  logic                              branch_link,
  output logic [BRANCH_CONDITION_WIDTH-1:0] condition,
  input  logic                              take,
  output logic [ADDRESS_WIDTH-1:0]          pc,
  output logic                              redirect,
  output logic                              flush,
  output logic                              link_write,
  output logic [ADDRESS_WIDTH-1:0]          link_address,
  output logic [15:0]                       branch_count,
  output logic [15:0]                       taken_count
);

  localparam logic [ADDRESS_WIDTH-1:0] PC_STEP    = ADDRESS_WIDTH'(INSTRUCTION_BYTES);
  localparam logic [3:0]               FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN,
    EVALUATE,
    FLUSH
  } state_t;

  state_t                            state_q, state_d;
  logic [ADDRESS_WIDTH-1:0]          pc_q, pc_d;
  logic [BRANCH_CONDITION_WIDTH-1:0] cond_q, cond_d;
  logic [ADDRESS_WIDTH-1:0]          target_q, target_d;
  logic [ADDRESS_WIDTH-1:0]          bpc_q, bpc_d;
  logic                              link_q, link_d;
  logic                              redirect_q, redirect_d;
  logic                              flush_q, flush_d;
  logic                              link_write_q, link_write_d;
  logic [ADDRESS_WIDTH-1:0]          link_address_q, link_address_d;
  logic [15:0]                       branch_count_q, branch_count_d;
  logic [15:0]                       taken_count_q, taken_count_d;
  logic [3:0]                        flush_cnt_q, flush_cnt_d;

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    cond_d         = cond_q;
    target_d       = target_q;
    bpc_d          = bpc_q;
    link_d         = link_q;
    redirect_d     = 1'b0;
    flush_d        = flush_q;
    link_write_d   = 1'b0;
    link_address_d = link_address_q;
    branch_count_d = branch_count_q;
    taken_count_d  = taken_count_q;
    flush_cnt_d    = flush_cnt_q;
    branch_ready   = 1'b0;

    case (state_q)
      RUN: begin
        branch_ready = 1'b1;
        // A new request wins over the sequential advance; pc holds while it resolves
        if (branch_valid) begin
          cond_d   = branch_condition;
          target_d = branch_target;
          bpc_d    = branch_pc;
          link_d   = branch_link;
          state_d  = EVALUATE;
        end else if (!stall) begin
          pc_d = pc_q + PC_STEP;
        end
      end
      EVALUATE: begin
        if (branch_count_q != 16'hFFFF) branch_count_d = branch_count_q + 16'd1;
        if (take) begin
          pc_d        = target_q;
          redirect_d  = 1'b1;
          flush_d     = 1'b1;
          flush_cnt_d = FLUSH_LAST;
          state_d     = FLUSH;
          if (taken_count_q != 16'hFFFF) taken_count_d = taken_count_q + 16'd1;
          if (link_q) begin
            link_write_d   = 1'b1;
            link_address_d = bpc_q + PC_STEP;
          end
        end else begin
          if (!stall) pc_d = pc_q + PC_STEP;
          state_d = RUN;
        end
      end
      FLUSH: begin
        if (flush_cnt_q == 4'd0) begin
          flush_d = 1'b0;
          state_d = RUN;
        end else begin
          flush_cnt_d = flush_cnt_q - 4'd1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= RUN;
      pc_q           <= RESET_VECTOR;
      cond_q         <= '1;
      target_q       <= '0;
      bpc_q          <= '0;
      link_q         <= 1'b0;
      redirect_q     <= 1'b0;
      flush_q        <= 1'b0;
      link_write_q   <= 1'b0;
      link_address_q <= '0;
      branch_count_q <= '0;
      taken_count_q  <= '0;
      flush_cnt_q    <= '0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      cond_q         <= cond_d;
      target_q       <= target_d;
      bpc_q          <= bpc_d;
      link_q         <= link_d;
      redirect_q     <= redirect_d;
      flush_q        <= flush_d;
      link_write_q   <= link_write_d;
      link_address_q <= link_address_d;
      branch_count_q <= branch_count_d;
      taken_count_q  <= taken_count_d;
      flush_cnt_q    <= flush_cnt_d;
    end
  end

  assign condition    = cond_q;
  assign pc           = pc_q;
  assign redirect     = redirect_q;
  assign flush        = flush_q;
  assign link_write   = link_write_q;
  assign link_address = link_address_q;
  assign branch_count = branch_count_q;
  assign taken_count  = taken_count_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// tb/tb_branch_sequencer.sv - randomized bench for branch_sequencer against a countdown-based reference model
module tb_branch_sequencer;

  localparam int          FC = 2;
  localparam logic [31:0] IB = 32'd4;
  localparam logic [31:0] RV = 32'd0;

  logic        clk = 1'b0;
  logic        reset, stall, branch_valid, branch_ready, branch_link, take;
  logic [3:0]  branch_condition, condition, flags;
  logic [31:0] branch_target, branch_pc, pc, link_address;
  logic        redirect, flush, link_write;
  logic [15:0] branch_count, taken_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  branch_sequencer #(
    .ADDRESS_WIDTH(32), .BRANCH_CONDITION_WIDTH(4), .RESET_VECTOR(RV),
    .INSTRUCTION_BYTES(4), .FLUSH_CYCLES(FC)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_valid(branch_valid),
    .branch_ready(branch_ready), .branch_condition(branch_condition),
    .branch_target(branch_target), .branch_pc(branch_pc), .branch_link(branch_link),
    .condition(condition), .take(take), .pc(pc), .redirect(redirect), .flush(flush),
    .link_write(link_write), .link_address(link_address),
    .branch_count(branch_count), .taken_count(taken_count)
  );

  // Evaluator: flags[0]=Z, [1]=C, [2]=N, [3]=V; 14 always, 15 invalid
  function automatic logic eval_take(input logic [3:0] c, input logic [3:0] f);
    case (c)
      4'd0:  return f[0];
      4'd1:  return !f[0];
      4'd2:  return f[1];
      4'd3:  return !f[1];
      4'd4:  return f[2];
      4'd5:  return !f[2];
      4'd6:  return f[3];
      4'd7:  return !f[3];
      4'd8:  return f[1] && !f[0];
      4'd9:  return !f[1] || f[0];
      4'd10: return f[2] == f[3];
      4'd11: return f[2] != f[3];
      4'd12: return !f[0] && (f[2] == f[3]);
      4'd13: return f[0] || (f[2] != f[3]);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  assign take = eval_take(condition, flags);

  logic [31:0] m_pc = '0, m_la = '0, m_tgt = '0, m_bpc = '0;
  logic [3:0]  m_cond = '1;
  logic        m_link = 1'b0, m_eval = 1'b0, m_redirect = 1'b0, m_lw = 1'b0;
  int          m_flush_left = 0;
  logic [15:0] m_bc = '0, m_tc = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    if (reset) begin
      m_pc = RV; m_cond = '1; m_eval = 1'b0; m_flush_left = 0;
      m_redirect = 1'b0; m_lw = 1'b0; m_la = '0; m_bc = '0; m_tc = '0;
    end else if (m_eval) begin
      m_eval = 1'b0;
      if (m_bc != 16'hFFFF) m_bc++;
      if (eval_take(m_cond, flags)) begin
        m_pc = m_tgt;
        if (m_tc != 16'hFFFF) m_tc++;
        m_redirect = 1'b1;
        m_flush_left = FC;
        if (m_link) begin
          m_lw = 1'b1;
          m_la = m_bpc + IB;
        end
      end else if (!stall) begin
        m_pc = m_pc + IB;
      end
    end else if (m_flush_left > 0) begin
      m_flush_left--;
      m_redirect = 1'b0;
      m_lw = 1'b0;
    end else if (branch_valid) begin
      m_cond = branch_condition; m_tgt = branch_target;
      m_bpc = branch_pc; m_link = branch_link; m_eval = 1'b1;
    end else if (!stall) begin
      m_pc = m_pc + IB;
    end
  endtask

  task automatic compare_all();
    check("pc", pc, m_pc);
    check("ready", 32'(branch_ready), 32'(!m_eval && m_flush_left == 0));
    check("flush", 32'(flush), 32'(m_flush_left > 0));
    check("redirect", 32'(redirect), 32'(m_redirect));
    check("link_write", 32'(link_write), 32'(m_lw));
    check("link_addr", link_address, m_la);
    check("bcount", 32'(branch_count), 32'(m_bc));
    check("tcount", 32'(taken_count), 32'(m_tc));
    check("cond", 32'(condition), 32'(m_cond));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic request(input logic [3:0] c, input logic [31:0] tgt,
                         input logic [31:0] bpc, input logic lnk);
    branch_valid = 1'b1; branch_condition = c; branch_target = tgt;
    branch_pc = bpc; branch_link = lnk;
  endtask

  initial begin
    int accepts;
    int last_acc;
    int flush_seen;
    reset = 1'b1; stall = 1'b0; branch_valid = 1'b0; branch_condition = '0;
    branch_target = '0; branch_pc = '0; branch_link = 1'b0; flags = '0;
    @(negedge clk);
    tick();
    reset = 1'b0;
    check("rst_pc", pc, RV);
    check("rst_cond", 32'(condition), 32'hF);
    check("rst_ready", 32'(branch_ready), 32'd1);

    // Sequential advance with a stall in the middle cycle
    stall = 1'b0; tick(); check("seq_pc1", pc, 32'h4);
    stall = 1'b1; tick(); check("seq_pc2", pc, 32'h4);
    stall = 1'b0; tick(); check("seq_pc3", pc, 32'h8);

    // Taken branch on Z with link
    flags = 4'b0001;
    request(4'd0, 32'h100, 32'h20, 1'b1);
    tick();
    check("eval_ready", 32'(branch_ready), 32'd0);
    check("eval_cond", 32'(condition), 32'd0);
    branch_valid = 1'b0;
    tick();
    check("tk_pc", pc, 32'h100);
    check("tk_redirect", 32'(redirect), 32'd1);
    check("tk_lw", 32'(link_write), 32'd1);
    check("tk_la", link_address, 32'h24);
    check("tk_tcount", 32'(taken_count), 32'd1);
    flush_seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (flush) flush_seen++;
      tick();
    end
    check("flush_len", 32'(flush_seen), 32'(FC));

    // Invalid code after a fresh reset resolves not taken
    reset = 1'b1; tick(); reset = 1'b0;
    flags = 4'b1111;
    request(4'd15, 32'h300, 32'h0, 1'b1);
    tick();
    branch_valid = 1'b0;
    tick();
    check("nt_pc", pc, 32'h4);
    check("nt_flush", 32'(flush), 32'd0);
    check("nt_bcount", 32'(branch_count), 32'd1);
    check("nt_tcount", 32'(taken_count), 32'd0);

    // Held request with an always-taken code: spacing is 2 + FC
    request(4'd14, 32'h40, 32'h10, 1'b0);
    accepts = 0; last_acc = -1;
    for (int i = 0; i < 16; i++) begin
      if (branch_ready) begin
        if (last_acc >= 0) check("acc_gap", 32'(i - last_acc), 32'(2 + FC));
        last_acc = i;
        accepts++;
      end
      tick();
    end
    check("acc_count", 32'(accepts), 32'd4);
    branch_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();

    // PC and link address wrap
    request(4'd14, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 1'b1);
    tick();
    branch_valid = 1'b0;
    tick();
    check("wrap_la", link_address, 32'h0);
    check("wrap_tgt", pc, 32'hFFFF_FFF8);
    for (int i = 0; i < FC; i++) tick();
    tick(); check("wrap_pc1", pc, 32'hFFFF_FFFC);
    tick(); check("wrap_pc2", pc, 32'h0);

    // Reset in the first flush cycle
    request(4'd14, 32'h500, 32'h0, 1'b0);
    tick();
    branch_valid = 1'b0;
    tick();
    check("mid_flush", 32'(flush), 32'd1);
    reset = 1'b1; tick(); reset = 1'b0;
    check("rf_pc", pc, RV);
    check("rf_flush", 32'(flush), 32'd0);
    check("rf_ready", 32'(branch_ready), 32'd1);
    check("rf_bcount", 32'(branch_count), 32'd0);

    // Saturating counters
    force dut.branch_count_q = 16'hFFFF;
    force dut.taken_count_q  = 16'hFFFF;
    m_bc = 16'hFFFF; m_tc = 16'hFFFF;
    tick();
    release dut.branch_count_q;
    release dut.taken_count_q;
    request(4'd14, 32'h80, 32'h0, 1'b0);
    tick();
    branch_valid = 1'b0;
    tick();
    check("sat_bcount", 32'(branch_count), 32'hFFFF);
    check("sat_tcount", 32'(taken_count), 32'hFFFF);
    for (int i = 0; i < FC; i++) tick();
    reset = 1'b1; tick(); reset = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      branch_valid     = ($urandom_range(0, 2) == 0);
      stall            = ($urandom_range(0, 3) == 0);
      branch_condition = 4'($urandom_range(0, 15));
      branch_target    = $urandom;
      branch_pc        = $urandom;
      branch_link      = 1'($urandom_range(0, 1));
      flags            = 4'($urandom_range(0, 15));
      reset            = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
